// File: rtl/ara_xif_issue_queue_pkg.sv
// ara_xif_issue_queue_pkg: entry types and helpers shared by the XIF issue queue.
// Entry field widths are fixed here; the top-level IdWidth/XLEN must match them.
package ara_xif_issue_queue_pkg;

    localparam int unsigned IqIdWidth = 4;
    localparam int unsigned IqXlen    = 64;

    typedef enum logic [1:0] {
        EMPTY,
        PENDING,
        COMMITTED,
        KILLED
    } iq_state_e;

    typedef struct packed {
        logic [31:0]            instr;
        logic [IqIdWidth-1:0]   id;
        logic [1:0][IqXlen-1:0] rs;
        logic                   writeback;
        logic                   is_vfp;
        iq_state_e              state;
    } iq_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != '1) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/ara_xif_iq_match.sv
// ara_xif_iq_match: finds the oldest PENDING entry whose id equals the commit id,
// scanning from the read pointer so that age order survives pointer wrap.
module ara_xif_iq_match
    import ara_xif_issue_queue_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter int unsigned IdWidth = IqIdWidth,
    localparam int unsigned PtrW   = $clog2(Depth)
) (
    input  iq_state_e          state [Depth],
    input  logic [IdWidth-1:0] ids   [Depth],
    input  logic [PtrW-1:0]    rd_ptr,
    input  logic [IdWidth-1:0] id,
    output logic               hit,
    output logic [PtrW-1:0]    idx
);

    logic [PtrW-1:0] slot;

    // Walk youngest to oldest so the last assignment is the oldest match.
    always_comb begin
        hit  = 1'b0;
        idx  = rd_ptr;
        slot = rd_ptr;
        for (int i = Depth - 1; i >= 0; i--) begin
            slot = rd_ptr + PtrW'(i);
            if (state[slot] == PENDING && ids[slot] == id) begin
                hit = 1'b1;
                idx = slot;
            end
        end
    end

endmodule

// File: rtl/ara_xif_issue_queue.sv
// ara_xif_issue_queue: in-order XIF issue queue holding instructions until commit/kill.
// Optional statistics counters are enabled by ARA_XIF_ISSUE_QUEUE_STATS_EN.
module ara_xif_issue_queue
    import ara_xif_issue_queue_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter int unsigned IdWidth = IqIdWidth,
    parameter int unsigned XLEN    = IqXlen,
    localparam int unsigned PtrW   = $clog2(Depth),
    localparam int unsigned CntW   = PtrW + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [IdWidth-1:0]  issue_id_i,
    input  logic [2*XLEN-1:0]   issue_rs_i,
    input  logic [1:0]          issue_rs_valid_i,
    input  logic                dec_accept_i,
    input  logic [1:0]          dec_reg_read_i,
    input  logic                dec_writeback_i,
    input  logic                dec_is_vfp_i,
    input  logic                commit_valid_i,
    input  logic [IdWidth-1:0]  commit_id_i,
    input  logic                commit_kill_i,
    output logic                acc_valid_o,
    input  logic                acc_ready_i,
    output logic [31:0]         acc_instr_o,
    output logic [IdWidth-1:0]  acc_id_o,
    output logic [2*XLEN-1:0]   acc_rs_o,
    output logic                acc_writeback_o,
    output logic                acc_is_vfp_o,
    output logic [CntW-1:0]     usage_o
`ifdef ARA_XIF_ISSUE_QUEUE_STATS_EN
    ,
    output logic [31:0]         stat_accepted_o,
    output logic [31:0]         stat_killed_o,
    output logic [31:0]         stat_full_stall_o
`endif
);

    iq_entry_t          entries [Depth];
    iq_state_e          states  [Depth];
    logic [IdWidth-1:0] ids     [Depth];
    iq_entry_t          head, new_entry;
    logic [PtrW-1:0]    rd_ptr, wr_ptr, hit_idx;
    logic               full, ops_ok, push, pop, hit, new_match;

    for (genvar g = 0; g < Depth; g++) begin : g_view
        assign states[g] = entries[g].state;
        assign ids[g]    = entries[g].id;
    end

    ara_xif_iq_match #(
        .Depth   (Depth),
        .IdWidth (IdWidth)
    ) i_match (
        .state  (states),
        .ids    (ids),
        .rd_ptr (rd_ptr),
        .id     (commit_id_i),
        .hit    (hit),
        .idx    (hit_idx)
    );

    assign head          = entries[rd_ptr];
    assign full          = usage_o == CntW'(Depth);
    assign ops_ok        = &(~dec_reg_read_i | issue_rs_valid_i);
    assign issue_ready_o = !flush_i && (!dec_accept_i || (!full && ops_ok));
    assign push          = issue_valid_i && issue_ready_o && dec_accept_i;
    assign acc_valid_o   = head.state == COMMITTED;
    assign pop           = (acc_valid_o && acc_ready_i) || head.state == KILLED;
    // The incoming entry is the youngest candidate, so it only takes the commit if nothing older does.
    assign new_match     = push && commit_valid_i && !hit && issue_id_i == commit_id_i;

    always_comb begin
        new_entry.instr     = issue_instr_i;
        new_entry.id        = issue_id_i;
        new_entry.rs        = issue_rs_i & {{XLEN{dec_reg_read_i[1]}}, {XLEN{dec_reg_read_i[0]}}};
        new_entry.writeback = dec_writeback_i;
        new_entry.is_vfp    = dec_is_vfp_i;
        new_entry.state     = !new_match ? PENDING : commit_kill_i ? KILLED : COMMITTED;
    end

    assign acc_instr_o     = acc_valid_o ? head.instr : '0;
    assign acc_id_o        = acc_valid_o ? head.id : '0;
    assign acc_rs_o        = acc_valid_o ? head.rs : '0;
    assign acc_writeback_o = acc_valid_o && head.writeback;
    assign acc_is_vfp_o    = acc_valid_o && head.is_vfp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) entries[i] <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            usage_o <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < Depth; i++) entries[i] <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            usage_o <= '0;
        end else begin
            if (pop) begin
                entries[rd_ptr].state <= EMPTY;
                rd_ptr                <= rd_ptr + PtrW'(1);
            end
            if (commit_valid_i && hit) entries[hit_idx].state <= commit_kill_i ? KILLED : COMMITTED;
            if (push) begin
                entries[wr_ptr] <= new_entry;
                wr_ptr          <= wr_ptr + PtrW'(1);
            end
            usage_o <= usage_o + CntW'(push) - CntW'(pop);
        end
    end

`ifdef ARA_XIF_ISSUE_QUEUE_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_accepted_o   <= '0;
            stat_killed_o     <= '0;
            stat_full_stall_o <= '0;
        end else begin
            stat_accepted_o   <= sat_inc(stat_accepted_o, push);
            stat_killed_o     <= sat_inc(stat_killed_o, head.state == KILLED);
            stat_full_stall_o <= sat_inc(stat_full_stall_o, issue_valid_i && dec_accept_i && full);
        end
    end
`endif

`ifndef SYNTHESIS
    // A commit must always name an instruction that is still pending.
    a_commit_hits: assert property (@(posedge clk_i) disable iff (!rst_ni)
        commit_valid_i && !flush_i |-> hit || new_match);
`endif

endmodule

// File: tb/tb_ara_xif_issue_queue.sv
// tb_ara_xif_issue_queue: scoreboard bench; expected dispatches are queued at issue
// time and compared whenever the queue hands an instruction to the dispatcher.
module tb_ara_xif_issue_queue;

    typedef struct packed {
        logic [31:0]  instr;
        logic [3:0]   id;
        logic [127:0] rs;
        logic         wb;
        logic         vfp;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         flush_i;
    logic         issue_valid_i;
    logic         issue_ready_o;
    logic [31:0]  issue_instr_i;
    logic [3:0]   issue_id_i;
    logic [127:0] issue_rs_i;
    logic [1:0]   issue_rs_valid_i;
    logic         dec_accept_i;
    logic [1:0]   dec_reg_read_i;
    logic         dec_writeback_i;
    logic         dec_is_vfp_i;
    logic         commit_valid_i;
    logic [3:0]   commit_id_i;
    logic         commit_kill_i;
    logic         acc_valid_o;
    logic         acc_ready_i;
    logic [31:0]  acc_instr_o;
    logic [3:0]   acc_id_o;
    logic [127:0] acc_rs_o;
    logic         acc_writeback_o;
    logic         acc_is_vfp_o;
    logic [2:0]   usage_o;
`ifdef ARA_XIF_ISSUE_QUEUE_STATS_EN
    logic [31:0]  stat_accepted_o, stat_killed_o, stat_full_stall_o;
`endif

    exp_t sb [$];
    exp_t got_e;
    int   total = 0;
    int   bad = 0;

    always #5 clk_i = ~clk_i;

    ara_xif_issue_queue dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_instr_i    (issue_instr_i),
        .issue_id_i       (issue_id_i),
        .issue_rs_i       (issue_rs_i),
        .issue_rs_valid_i (issue_rs_valid_i),
        .dec_accept_i     (dec_accept_i),
        .dec_reg_read_i   (dec_reg_read_i),
        .dec_writeback_i  (dec_writeback_i),
        .dec_is_vfp_i     (dec_is_vfp_i),
        .commit_valid_i   (commit_valid_i),
        .commit_id_i      (commit_id_i),
        .commit_kill_i    (commit_kill_i),
        .acc_valid_o      (acc_valid_o),
        .acc_ready_i      (acc_ready_i),
        .acc_instr_o      (acc_instr_o),
        .acc_id_o         (acc_id_o),
        .acc_rs_o         (acc_rs_o),
        .acc_writeback_o  (acc_writeback_o),
        .acc_is_vfp_o     (acc_is_vfp_o),
        .usage_o          (usage_o)
`ifdef ARA_XIF_ISSUE_QUEUE_STATS_EN
        ,
        .stat_accepted_o   (stat_accepted_o),
        .stat_killed_o     (stat_killed_o),
        .stat_full_stall_o (stat_full_stall_o)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle;
        issue_valid_i    = 1'b0;
        dec_accept_i     = 1'b0;
        dec_reg_read_i   = 2'b00;
        issue_rs_valid_i = 2'b00;
        commit_valid_i   = 1'b0;
        commit_kill_i    = 1'b0;
        flush_i          = 1'b0;
    endtask

    task automatic drive_issue(input logic [3:0] id, input logic [31:0] instr,
                               input logic [63:0] rs1, input logic [63:0] rs2,
                               input logic [1:0] rr, input bit will_dispatch);
        exp_t e;
        issue_valid_i    = 1'b1;
        dec_accept_i     = 1'b1;
        issue_id_i       = id;
        issue_instr_i    = instr;
        issue_rs_i       = {rs2, rs1};
        dec_reg_read_i   = rr;
        issue_rs_valid_i = 2'b11;
        dec_writeback_i  = id[0];
        dec_is_vfp_i     = id[1];
        if (will_dispatch) begin
            e.instr = instr;
            e.id    = id;
            e.rs    = {rr[1] ? rs2 : 64'h0, rr[0] ? rs1 : 64'h0};
            e.wb    = id[0];
            e.vfp   = id[1];
            sb.push_back(e);
        end
    endtask

    task automatic drive_commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
    endtask

    // Handshake completes at the next rising edge; inputs only change just after rising edges.
    always @(negedge clk_i) begin
        if (rst_ni && acc_valid_o && acc_ready_i) begin
            check("sb_has_entry", 128'(sb.size() != 0), 128'd1);
            if (sb.size() != 0) begin
                got_e = sb.pop_front();
                check("acc_id", acc_id_o, got_e.id);
                check("acc_instr", acc_instr_o, got_e.instr);
                check("acc_rs", acc_rs_o, got_e.rs);
                check("acc_wb", acc_writeback_o, got_e.wb);
                check("acc_vfp", acc_is_vfp_o, got_e.vfp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        idle();
        acc_ready_i     = 1'b1;
        issue_id_i      = '0;
        issue_instr_i   = '0;
        issue_rs_i      = '0;
        commit_id_i     = '0;
        dec_writeback_i = 1'b0;
        dec_is_vfp_i    = 1'b0;
        rst_ni          = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_usage", usage_o, 0);
        check("rst_valid", acc_valid_o, 0);
        check("rst_id", acc_id_o, 0);
        check("rst_rs", acc_rs_o, 0);
        check("rst_instr", acc_instr_o, 0);
        rst_ni = 1'b1;
        tick();

        // Accept then commit; rs2 is not read so it must come out as zero.
        drive_issue(4'd3, 32'h0000_0357, 64'h1234, 64'hdead_beef, 2'b01, 1'b1);
        #1 check("t1_ready", issue_ready_o, 1);
        tick(); idle();
        check("t1_usage1", usage_o, 1);
        check("t1_pending", acc_valid_o, 0);
        drive_commit(4'd3, 1'b0);
        tick(); idle();
        check("t1_valid", acc_valid_o, 1);
        check("t1_rs", acc_rs_o, {64'h0, 64'h1234});
        check("t1_usage_hold", usage_o, 1);
        tick();
        check("t1_usage0", usage_o, 0);
        check("t1_drained", acc_valid_o, 0);

        // Enqueue and commit in the same cycle: dispatchable one cycle later.
        drive_issue(4'd7, 32'h0000_0757, 64'h77, 64'h78, 2'b11, 1'b1);
        drive_commit(4'd7, 1'b0);
        tick(); idle();
        check("lat_valid", acc_valid_o, 1);
        check("lat_id", acc_id_o, 7);
        tick();
        check("lat_usage0", usage_o, 0);

        // Kill at head is dropped silently.
        drive_issue(4'd1, 32'h0000_0157, 64'h11, 64'h12, 2'b11, 1'b0);
        tick();
        drive_issue(4'd2, 32'h0000_0257, 64'h21, 64'h22, 2'b10, 1'b1);
        tick(); idle();
        drive_commit(4'd1, 1'b1);
        tick(); idle();
        check("t2_killed_quiet", acc_valid_o, 0);
        check("t2_usage2", usage_o, 2);
        drive_commit(4'd2, 1'b0);
        tick(); idle();
        check("t2_valid", acc_valid_o, 1);
        check("t2_id", acc_id_o, 2);
        check("t2_usage1", usage_o, 1);
        tick();
        check("t2_usage0", usage_o, 0);

        // Full queue and back-pressure.
        acc_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_issue(4'(8 + i), 32'h0000_0800 + 32'(i), 64'(i + 1), 64'(i + 100), 2'b11, 1'b1);
            tick();
        end
        idle();
        check("t3_full", usage_o, 4);
        drive_issue(4'd12, 32'h0000_0c57, 64'h0, 64'h0, 2'b00, 1'b0);
        #1 check("t3_full_stall", issue_ready_o, 0);
        dec_accept_i = 1'b0;
        #1 check("t3_reject_ready", issue_ready_o, 1);
        tick(); idle();
        check("t3_reject_noenq", usage_o, 4);
        drive_commit(4'd8, 1'b0);
        tick(); idle();
        check("t3_head_valid", acc_valid_o, 1);
        check("t3_head_id", acc_id_o, 8);
        acc_ready_i = 1'b1;
        drive_issue(4'd13, 32'h0000_0d57, 64'h0, 64'h0, 2'b00, 1'b0);
        #1 check("t3_pop_no_bypass", issue_ready_o, 0);
        tick(); idle();
        check("t3_usage3", usage_o, 3);
        for (int i = 9; i < 12; i++) begin
            drive_commit(4'(i), 1'b0);
            tick(); idle();
        end
        repeat (3) tick();
        check("t3_usage0", usage_o, 0);

        // Operand wait: both sources read, rs2 not yet valid.
        drive_issue(4'd4, 32'h0000_0457, 64'haaaa, 64'hbbbb, 2'b11, 1'b0);
        issue_rs_valid_i = 2'b01;
        #1 check("t4_wait", issue_ready_o, 0);
        tick();
        check("t4_noenq", usage_o, 0);
        drive_issue(4'd4, 32'h0000_0457, 64'haaaa, 64'hbbbb, 2'b11, 1'b1);
        #1 check("t4_ready", issue_ready_o, 1);
        tick(); idle();
        check("t4_usage1", usage_o, 1);
        drive_commit(4'd4, 1'b0);
        tick(); idle();
        check("t4_rs", acc_rs_o, {64'hbbbb, 64'haaaa});
        tick();
        check("t4_usage0", usage_o, 0);

        // Duplicate ids: the older one commits first; outputs hold under stall.
        acc_ready_i = 1'b0;
        drive_issue(4'd5, 32'h0000_a557, 64'h51, 64'h52, 2'b01, 1'b1);
        tick();
        drive_issue(4'd5, 32'h0000_b557, 64'h53, 64'h54, 2'b10, 1'b1);
        tick(); idle();
        drive_commit(4'd5, 1'b0);
        tick(); idle();
        check("t5_valid", acc_valid_o, 1);
        check("t5_older", acc_instr_o, 32'h0000_a557);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_stable_valid", acc_valid_o, 1);
            check("t5_stable_instr", acc_instr_o, 32'h0000_a557);
            check("t5_stable_rs", acc_rs_o, {64'h0, 64'h51});
        end
        acc_ready_i = 1'b1;
        tick();
        check("t5_younger_pending", acc_valid_o, 0);
        check("t5_usage1", usage_o, 1);
        drive_commit(4'd5, 1'b0);
        tick(); idle();
        check("t5_younger", acc_instr_o, 32'h0000_b557);
        tick();
        check("t5_usage0", usage_o, 0);

        // Flush with three entries; the dispatch in the flush cycle completes.
        acc_ready_i = 1'b0;
        drive_issue(4'd1, 32'h0000_0161, 64'h61, 64'h62, 2'b11, 1'b1);
        tick();
        drive_issue(4'd2, 32'h0000_0262, 64'h63, 64'h64, 2'b11, 1'b0);
        tick();
        drive_issue(4'd3, 32'h0000_0363, 64'h65, 64'h66, 2'b11, 1'b0);
        tick(); idle();
        drive_commit(4'd1, 1'b0);
        tick(); idle();
        check("t6_usage3", usage_o, 3);
        acc_ready_i = 1'b1;
        flush_i     = 1'b1;
        drive_commit(4'd2, 1'b0);
        drive_issue(4'd9, 32'h0000_0969, 64'h0, 64'h0, 2'b00, 1'b0);
        #1 check("t6_flush_ready", issue_ready_o, 0);
        tick(); idle();
        check("t6_flush_usage", usage_o, 0);
        check("t6_flush_valid", acc_valid_o, 0);
        drive_issue(4'd4, 32'h0000_0464, 64'h44, 64'h45, 2'b01, 1'b1);
        drive_commit(4'd4, 1'b0);
        tick(); idle();
        check("t6_after_valid", acc_valid_o, 1);
        check("t6_after_id", acc_id_o, 4);
        tick();
        check("t6_after_usage0", usage_o, 0);

        // Asynchronous reset in the middle of a cycle.
        acc_ready_i = 1'b0;
        drive_issue(4'd6, 32'h0000_0666, 64'h66, 64'h67, 2'b11, 1'b0);
        drive_commit(4'd6, 1'b0);
        tick(); idle();
        check("t7_pre_valid", acc_valid_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("t7_rst_usage", usage_o, 0);
        check("t7_rst_valid", acc_valid_o, 0);
        check("t7_rst_id", acc_id_o, 0);
        #4 rst_ni = 1'b1;
        tick();
        acc_ready_i = 1'b1;
        drive_issue(4'd9, 32'h0000_0999, 64'h99, 64'h98, 2'b10, 1'b1);
        drive_commit(4'd9, 1'b0);
        tick(); idle();
        check("t7_post_valid", acc_valid_o, 1);
        check("t7_post_id", acc_id_o, 9);
        tick();
        check("t7_post_usage0", usage_o, 0);

        check("sb_drained", 128'(sb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
